// File: rtl/mul_seq_ctrl_if.sv
// Handshake and ALU-sharing bundle between the pipeline and the multiply sequencer.
// master = pipeline/ALU side, slave = mul_seq_ctrl.
`ifndef ALU_B_OP_W
`define ALU_B_OP_W    1
`define ALU_B_OP_REGB 1'b1
`define ALU_B_OP_IM   1'b0
`endif

interface mul_seq_ctrl_if #(
  parameter int DATA_W = 16
);
  logic                   start;
  logic                   flush;
  logic [DATA_W-1:0]      op_a;
  logic [DATA_W-1:0]      op_b;
  logic [DATA_W-1:0]      alu_result;
  logic                   alu_own;
  logic [DATA_W-1:0]      alu_a_data;
  logic [DATA_W-1:0]      alu_b_reg;
  logic [DATA_W-1:0]      alu_b_imm;
  logic [`ALU_B_OP_W-1:0] alu_b_op;
  logic                   busy;
  logic                   stall;
  logic                   done;
  logic [DATA_W-1:0]      result;

  modport master (
    output start, flush, op_a, op_b, alu_result,
    input  alu_own, alu_a_data, alu_b_reg, alu_b_imm, alu_b_op,
           busy, stall, done, result
  );

  modport slave (
    input  start, flush, op_a, op_b, alu_result,
    output alu_own, alu_a_data, alu_b_reg, alu_b_imm, alu_b_op,
           busy, stall, done, result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiply sequencer borrowing the shared ALU, one step per cycle; done pulse after DATA_W+1 cycles.
// Optional MUL_EARLY_EXIT_EN ends the sequence as soon as the remaining multiplier is zero.
`ifndef ALU_B_OP_W
`define ALU_B_OP_W    1
`define ALU_B_OP_REGB 1'b1
`define ALU_B_OP_IM   1'b0
`endif

module mul_seq_ctrl #(
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          rst,
  mul_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, mcand, mplr, res_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, step, mplr_zero;

`ifdef MUL_EARLY_EXIT_EN
  assign mplr_zero = (mplr == '0);
`else
  assign mplr_zero = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = !mplr_zero;
        // flush outranks both the normal and early completion
        if (bus.flush)
          state_nxt = IDLE;
        else if (mplr_zero || cnt == LAST_CNT)
          state_nxt = DONE;
      end
      DONE: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= '0;
        mcand <= bus.op_a;
        mplr  <= bus.op_b;
        cnt   <= '0;
      end else if (step) begin
        acc   <= bus.alu_result;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (state == RUN && state_nxt == DONE)
        res_q <= step ? bus.alu_result : acc;
    end
  end

  // ALU operands are quiet whenever this block does not own the ALU
  assign bus.alu_own    = step;
  assign bus.alu_a_data = step ? acc : '0;
  assign bus.alu_b_reg  = step ? mcand : '0;
  assign bus.alu_b_imm  = '0;
  assign bus.alu_b_op   = (step && mplr[0]) ? `ALU_B_OP_REGB : `ALU_B_OP_IM;
  assign bus.busy       = (state == RUN);
  assign bus.stall      = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.result     = res_q;
endmodule
